// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory, then releases the mips core from reset.
// Optional feature macro LOADER_CSUM_EN appends a 32-bit XOR checksum that must match before release.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, core held in reset
// HDR0  | receiving word-count low byte
// HDR1  | receiving word-count high byte
// DATA  | receiving data bytes, writing one IM word per 4 bytes
// CSUM  | receiving the 4-byte XOR checksum (LOADER_CSUM_EN only)
// DONE  | image loaded, core released one cycle after entry
// ERROR | load aborted, core held in reset
module imem_boot_loader #(
    parameter int unsigned     AW        = 15,
    parameter logic [AW-1:0]   BASE_ADDR = AW'(15'h0C00),
    parameter logic [15:0]     MAX_WORDS = 16'h0090
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   word_cnt
);

`ifdef LOADER_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
    localparam state_t S_POST = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERROR} state_t;
    localparam state_t S_POST = S_DONE;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rx_ready;
    logic          r_im_we;
    logic [AW-1:0] r_im_addr;
    logic [31:0]   r_im_wdata;
    logic          r_cpu_rst;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [15:0]   r_word_cnt;
    logic [15:0]   r_count;
    logic [1:0]    r_idx;
    logic [23:0]   r_shift;
`ifdef LOADER_CSUM_EN
    logic [31:0]   r_xor;
`endif

    logic          w_xfer;
    logic          w_begin;
    logic          w_word_full;
    logic          w_last_word;
    logic          w_busy_nxt;
    logic [15:0]   w_hdr_count;
    logic [31:0]   w_word;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_begin     = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_hdr_count = {rx_data, r_count[7:0]};
    assign w_word      = {rx_data, r_shift};
    assign w_word_full = w_xfer && (r_state == S_DATA) && (r_idx == 2'd3);
    // The last word's write cycle must not accept a byte that belongs to nothing.
    assign w_last_word = w_word_full && ((r_word_cnt + 16'd1) == r_count);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_state_nxt = S_HDR0;
            S_HDR0: if (w_xfer) w_state_nxt = S_HDR1;
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_hdr_count > MAX_WORDS)   w_state_nxt = S_ERROR;
                    else if (w_hdr_count == 16'd0) w_state_nxt = S_POST;
                    else                           w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (r_word_cnt == r_count) w_state_nxt = S_POST;
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                if (w_xfer && r_idx == 2'd3)
                    w_state_nxt = (w_word == r_xor) ? S_DONE : S_ERROR;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            S_HDR0, S_HDR1, S_DATA: w_busy_nxt = 1'b1;
`ifdef LOADER_CSUM_EN
            S_CSUM:                 w_busy_nxt = 1'b1;
`endif
            default:                w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_word_cnt <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
`ifdef LOADER_CSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= w_busy_nxt && !w_last_word;
            r_busy     <= w_busy_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_error    <= (w_state_nxt == S_ERROR);
            r_cpu_rst  <= !(r_state == S_DONE && w_state_nxt == S_DONE);
            r_im_we    <= 1'b0;
            if (w_begin) begin
                r_word_cnt <= '0;
                r_idx      <= '0;
`ifdef LOADER_CSUM_EN
                r_xor      <= '0;
`endif
            end
            if (w_xfer) r_shift <= {rx_data, r_shift[23:8]};
            if (w_xfer && r_state == S_HDR0) r_count[7:0] <= rx_data;
            if (w_xfer && r_state == S_HDR1) r_count <= w_hdr_count;
`ifdef LOADER_CSUM_EN
            if (w_xfer && (r_state == S_DATA || r_state == S_CSUM)) r_idx <= r_idx + 2'd1;
`else
            if (w_xfer && r_state == S_DATA) r_idx <= r_idx + 2'd1;
`endif
            if (w_word_full) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= BASE_ADDR + AW'(r_word_cnt);
                r_im_wdata <= w_word;
                r_word_cnt <= r_word_cnt + 16'd1;
`ifdef LOADER_CSUM_EN
                r_xor      <= r_xor ^ w_word;
`endif
            end
        end
    end

    assign rx_ready = r_rx_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign cpu_rst  = r_cpu_rst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a queue of expected IM writes is filled from a simple
// image model and drained by an independent write monitor; load status is checked per load.
module tb_imem_boot_loader;
    localparam int          AW   = 15;
    localparam logic [14:0] BASE = 15'h0C00;
    localparam logic [15:0] MAXW = 16'h0090;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   word_cnt;

    imem_boot_loader #(.AW(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          n_writes = 0;
    wr_t         exp_q[$];
    logic [31:0] wbuf[0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write monitor: every IM strobe must match the oldest outstanding expected write.
    always @(negedge Clk) begin
        if (Rst_n && im_we) begin
            wr_t w;
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_im_we actual_addr=%h required=none", im_addr);
            end else begin
                w = exp_q.pop_front();
                check("im_addr", 32'(im_addr), 32'(w.addr));
                check("im_wdata", im_wdata, w.data);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_im_we"},    32'(im_we),    32'd0);
        check({tag, "_im_addr"},  32'(im_addr),  32'd0);
        check({tag, "_im_wdata"}, im_wdata,      32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // Presents one byte; returns at the negedge preceding the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget = 0;
        bit sent = 1'b0;
        while (!sent) begin
            @(negedge Clk);
            if (rnd && $urandom_range(1, 0) == 0) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready) sent = 1'b1;
            end
            budget++;
            if (!sent && budget > 200) begin
                checks++;
                failures++;
                $display("FAIL byte_accept_timeout actual=no_ready required=ready");
                sent = 1'b1;
            end
        end
    endtask

    task automatic run_load(input string tag, input logic [15:0] cnt, input bit rnd, input bit bad_csum);
        logic [31:0] x = 32'h0;
        bit          over;
        bit          exp_err;
        int          waited = 0;
        over    = (cnt > MAXW);
        exp_err = over || (CSUM_EN && bad_csum);
        n_writes = 0;
        if (!over) begin
            for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back(wr_t'({BASE + 15'(i), wbuf[i]}));
                x ^= wbuf[i];
            end
        end
        pulse_start();
        check({tag, "_start_busy"},  32'(busy),     32'd1);
        check({tag, "_start_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_start_flags"}, 32'({done, error}), 32'd0);
        send_byte(cnt[7:0], rnd);
        send_byte(cnt[15:8], rnd);
        if (!over) begin
            for (int i = 0; i < int'(cnt); i++)
                for (int b = 0; b < 4; b++) send_byte(wbuf[i][8*b +: 8], rnd);
            if (CSUM_EN) begin
                if (bad_csum) x ^= 32'h7;
                for (int b = 0; b < 4; b++) send_byte(x[8*b +: 8], rnd);
            end
        end
        @(negedge Clk);
        rx_valid = 1'b0;
        while (!(done || error) && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_done"},  32'(done),  32'(!exp_err));
        check({tag, "_cpu_rst_first"}, 32'(cpu_rst), 32'd1);
        @(negedge Clk);
        check({tag, "_cpu_rst_after"}, 32'(cpu_rst), 32'(exp_err));
        check({tag, "_busy_end"},     32'(busy),     32'd0);
        check({tag, "_ready_end"},    32'(rx_ready), 32'd0);
        check({tag, "_word_cnt"},     32'(word_cnt), over ? 32'd0 : 32'(cnt));
        check({tag, "_writes"},       32'(n_writes), over ? 32'd0 : 32'(cnt));
        check({tag, "_pending"},      32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_values("rst");
        Rst_n = 1'b1;
        @(negedge Clk);
        check_reset_values("idle");

        wbuf[0] = 32'h2008_0013;
        wbuf[1] = 32'h2009_0014;
        run_load("basic", 16'd2, 1'b0, 1'b0);
        run_load("zero", 16'd0, 1'b0, 1'b0);
        run_load("over", 16'h0091, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        run_load("stall_cont", 16'd3, 1'b0, 1'b0);
        run_load("stall_rand", 16'd3, 1'b1, 1'b0);

        for (int i = 0; i < int'(MAXW); i++) wbuf[i] = $urandom;
        run_load("max", MAXW, 1'b0, 1'b0);

        // Reset in the middle of the second data word.
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        for (int i = 0; i < 3; i++) exp_q.push_back(wr_t'({BASE + 15'(i), wbuf[i]}));
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(wbuf[k/4][8*(k%4) +: 8], 1'b0);
        @(negedge Clk);
        rx_valid = 1'b0;
        Rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        check("midrst_pending", 32'(exp_q.size()), 32'd2);
        repeat (2) @(negedge Clk);
        check("midrst_no_we", 32'(im_we), 32'd0);
        exp_q.delete();
        Rst_n = 1'b1;
        wbuf[0] = $urandom;
        run_load("post_rst", 16'd1, 1'b0, 1'b0);

        wbuf[0] = 32'h0000_0001;
        wbuf[1] = 32'h0000_0003;
        run_load("csum_good", 16'd2, 1'b0, 1'b0);
        run_load("csum_bad", 16'd2, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            logic [15:0] c;
            c = 16'($urandom_range(6, 1));
            for (int i = 0; i < int'(c); i++) wbuf[i] = $urandom;
            run_load("random", c, 1'b1, 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
